dcache_wb_dm: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It is the responder for the CPU datapath's dcache request interface, and the initiator for a word-wide DRAM burst interface. It answers CPU loads and stores, raising a same-cycle ready on a hit. On a miss it writes back a dirty victim line, refills the new line, and raises transfer_in_progress so the pipeline stalls.

---
 rtl/dcache_wb_dm.sv | 149 ++++++++++++++
 tb/tb_dcache_wb_dm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with a word-wide DRAM burst port.
// Hits answer combinationally in IDLE; misses write back a dirty victim, then refill the line.
module dcache_wb_dm #(
  parameter int ADDR_W     = 12,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     dcache_address,
  input  logic                  dcache_dataRequest,
  input  logic                  dcache_rw,
  input  logic [WORD_W-1:0]     dcache_writeData,
  input  logic [WORD_W/8-1:0]   dcache_byte_en,
  output logic [WORD_W-1:0]     dcache_readData,
  output logic                  dcache_data_ready,
  output logic                  transfer_in_progress,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int OFF_W = 2;
  localparam int WB_W  = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - WB_W - IDX_W;
  localparam int LANES = WORD_W / 8;
  localparam logic [WB_W-1:0] LAST_BEAT = WB_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;

  logic [1:0]        state;
  logic [WB_W-1:0]   beat;
  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_idx;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [WORD_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WB_W-1:0]  req_word;
  logic             hit;
  logic             last_beat;
  logic             unused_offset;

  assign req_tag       = dcache_address[ADDR_W-1 -: TAG_W];
  assign req_idx       = dcache_address[OFF_W+WB_W +: IDX_W];
  assign req_word      = dcache_address[OFF_W +: WB_W];
  assign unused_offset = ^dcache_address[OFF_W-1:0];

  assign hit       = (state == S_IDLE) && dcache_dataRequest && valid[req_idx]
                     && (tag_mem[req_idx] == req_tag);
  assign last_beat = (beat == LAST_BEAT);

  assign dcache_data_ready    = hit;
  assign dcache_readData      = hit ? data_mem[{req_idx, req_word}] : '0;
  assign transfer_in_progress = (state != S_IDLE);
  assign mem_req              = transfer_in_progress;
  assign mem_we               = (state == S_WRITEBACK);

  // Writeback addresses come from the resident tag; refill addresses from the latched miss tag.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_WRITEBACK) begin
      mem_addr  = {tag_mem[lat_idx], lat_idx, beat, 2'b00};
      mem_wdata = data_mem[{lat_idx, beat}];
    end else if (state == S_REFILL) begin
      mem_addr  = {lat_tag, lat_idx, beat, 2'b00};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      beat    <= '0;
      lat_tag <= '0;
      lat_idx <= '0;
      valid   <= '0;
      dirty   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit && dcache_rw) begin
            dirty[req_idx] <= 1'b1;
          end else if (dcache_dataRequest && !hit) begin
            lat_tag <= req_tag;
            lat_idx <= req_idx;
            beat    <= '0;
            state   <= (valid[req_idx] && dirty[req_idx]) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat           <= '0;
              dirty[lat_idx] <= 1'b0;
              state          <= S_REFILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat           <= '0;
              valid[lat_idx] <= 1'b1;
              dirty[lat_idx] <= 1'b0;
              state          <= S_IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit && dcache_rw) begin
        for (int l = 0; l < LANES; l++) begin
          if (dcache_byte_en[l]) begin
            data_mem[{req_idx, req_word}][l*8 +: 8] <= dcache_writeData[l*8 +: 8];
          end
        end
      end else if (state == S_REFILL && mem_ready) begin
        data_mem[{lat_idx, beat}] <= mem_rdata;
        if (last_beat) begin
          tag_mem[lat_idx] <= lat_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Self-checking bench for dcache_wb_dm: a flat golden memory plus a per-line residency model
// predict hits, burst beats and returned data; a bench-side DRAM answers the bursts.
`timescale 1ns/1ps
module tb_dcache_wb_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] dcache_address;
  logic        dcache_dataRequest;
  logic        dcache_rw;
  logic [31:0] dcache_writeData;
  logic [3:0]  dcache_byte_en;
  logic [31:0] dcache_readData;
  logic        dcache_data_ready;
  logic        transfer_in_progress;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  dcache_wb_dm dut (
    .clk                  (clk),
    .reset                (reset),
    .dcache_address       (dcache_address),
    .dcache_dataRequest   (dcache_dataRequest),
    .dcache_rw            (dcache_rw),
    .dcache_writeData     (dcache_writeData),
    .dcache_byte_en       (dcache_byte_en),
    .dcache_readData      (dcache_readData),
    .dcache_data_ready    (dcache_data_ready),
    .transfer_in_progress (transfer_in_progress),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ready            (mem_ready)
  );

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
  } beat_t;

  // Reference: the cache must look like a flat memory; residency model predicts hits/bursts.
  logic [31:0] gold [1024];
  logic [31:0] dram [1024];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [3:0]  m_tag   [16];
  beat_t       exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr = 0, n_rd = 0;
  int delay_cnt = 0;
  bit rand_delay = 1'b0;

  // Inputs staged here are applied just after the next falling edge.
  logic        s_reset = 1'b1;
  logic [11:0] s_addr = '0;
  logic        s_req = 1'b0, s_rw = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  // One cycle: apply inputs, act as DRAM, then sample outputs 1ns later.
  task automatic step();
    beat_t e;
    @(negedge clk);
    reset              = s_reset;
    dcache_address     = s_addr;
    dcache_dataRequest = s_req;
    dcache_rw          = s_rw;
    dcache_writeData   = s_wdata;
    dcache_byte_en     = s_be;
    mem_ready          = 1'b0;
    mem_rdata          = 32'h0;
    if (mem_req && !reset) begin
      if (delay_cnt > 0) begin
        delay_cnt--;
      end else begin
        mem_ready = 1'b1;
        delay_cnt = rand_delay ? int'($urandom_range(0, 2)) : 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL beat_unexpected: addr %h we %0d, no beat expected", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          check("beat_we", 32'(mem_we), 32'(e.we));
          check("beat_addr", 32'(mem_addr), 32'(e.addr));
          if (mem_we) begin
            check("beat_wdata", mem_wdata, e.data);
            dram[mem_addr[11:2]] = mem_wdata;
            n_wr++;
          end else begin
            mem_rdata = dram[mem_addr[11:2]];
            n_rd++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic push_miss_beats(input logic [11:0] addr);
    beat_t e;
    logic [3:0] idx, tag;
    idx = addr[7:4];
    tag = addr[11:8];
    if (m_valid[idx] && m_dirty[idx]) begin
      for (int b = 0; b < 4; b++) begin
        e.we = 1'b1;
        e.addr = {m_tag[idx], idx, 2'(b), 2'b00};
        e.data = gold[e.addr[11:2]];
        exp_q.push_back(e);
      end
    end
    for (int b = 0; b < 4; b++) begin
      e.we = 1'b0;
      e.addr = {tag, idx, 2'(b), 2'b00};
      e.data = 32'h0;
      exp_q.push_back(e);
    end
  endtask

  // Issue one request and follow it to completion; drop=1 withdraws it after the burst starts.
  task automatic do_req(input logic [11:0] addr, input bit rw, input logic [31:0] wd,
                        input logic [3:0] be, input bit drop,
                        output int lat, output logic [31:0] rd);
    logic [3:0] idx, tag;
    bit hit;
    idx = addr[7:4];
    tag = addr[11:8];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    lat = 0;
    if (!hit) push_miss_beats(addr);
    s_addr = addr; s_req = 1'b1; s_rw = rw; s_wdata = wd; s_be = be;
    step();
    if (!hit) begin
      check("miss_ready", 32'(dcache_data_ready), 32'h0);
      check("miss_tip", 32'(transfer_in_progress), 32'h0);
      if (drop) begin
        s_req = 1'b0;
        s_addr = addr ^ 12'hF00;
      end
      while (exp_q.size() > 0 && lat < 60) begin
        step();
        lat++;
        check("burst_tip", 32'(transfer_in_progress), 32'h1);
        check("burst_ready", 32'(dcache_data_ready), 32'h0);
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        $display("FAIL burst_timeout: %0d beats still pending for addr %h", exp_q.size(), addr);
        exp_q.delete();
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      step();
      lat++;
    end
    rd = dcache_readData;
    check("done_tip", 32'(transfer_in_progress), 32'h0);
    check("done_mem_req", 32'(mem_req), 32'h0);
    if (drop) begin
      check("drop_ready", 32'(dcache_data_ready), 32'h0);
    end else begin
      check("ready", 32'(dcache_data_ready), 32'h1);
      check("read_data", dcache_readData, gold[addr[11:2]]);
      if (rw) begin
        gold[addr[11:2]] = merge(gold[addr[11:2]], wd, be);
        m_dirty[idx] = 1'b1;
      end
    end
    s_req = 1'b0;
  endtask

  // Reset loses dirty data, so the golden view falls back to DRAM.
  task automatic do_reset();
    s_reset = 1'b1;
    s_req = 1'b0;
    step();
    s_reset = 1'b0;
    exp_q.delete();
    delay_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) gold[i] = dram[i];
    step();
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_tip", 32'(transfer_in_progress), 32'h0);
    check("rst_ready", 32'(dcache_data_ready), 32'h0);
    check("rst_rdata", dcache_readData, 32'h0);
  endtask

  initial begin
    int lat, w0, r0;
    logic [31:0] rd;
    logic [11:0] a;
    reset = 1'b1; dcache_address = '0; dcache_dataRequest = 1'b0; dcache_rw = 1'b0;
    dcache_writeData = '0; dcache_byte_en = '0; mem_rdata = '0; mem_ready = 1'b0;
    for (int i = 0; i < 1024; i++) dram[i] = $urandom;
    for (int b = 0; b < 4; b++) dram[16 + b] = 32'hA0 + 32'(b);
    for (int i = 0; i < 16; i++) m_tag[i] = '0;
    do_reset();

    // Cold read miss: four refill beats, ready one cycle after the last one.
    r0 = n_rd;
    do_req(12'h044, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t1_rdata", rd, 32'h000000A1);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_read_beats", 32'(n_rd - r0), 32'd4);

    // Same-line read hits in the request cycle.
    do_req(12'h048, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t2_rdata", rd, 32'h000000A2);
    check("t2_latency", 32'(lat), 32'd0);

    // Partial store, then read back the merged word.
    do_req(12'h044, 1'b1, 32'hDEADBEEF, 4'b0011, 1'b0, lat, rd);
    check("t3_wr_latency", 32'(lat), 32'd0);
    do_req(12'h044, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t3_rdata", rd, 32'h0000BEEF);

    // Conflict miss on a dirty line: writeback then refill.
    w0 = n_wr; r0 = n_rd;
    do_req(12'h144, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t4_write_beats", 32'(n_wr - w0), 32'd4);
    check("t4_read_beats", 32'(n_rd - r0), 32'd4);
    check("t4_latency", 32'(lat), 32'd9);
    check("t4_dram_beat1", dram[17], 32'h0000BEEF);

    // Reset after the second refill beat aborts the burst; the line must refill fully later.
    a = 12'h244;
    push_miss_beats(a);
    s_addr = a; s_req = 1'b1; s_rw = 1'b0; s_be = 4'h0;
    r0 = n_rd;
    lat = 0;
    while (n_rd - r0 < 2 && lat < 40) begin
      step();
      lat++;
    end
    check("t5_beats_before_reset", 32'(n_rd - r0), 32'd2);
    do_reset();
    r0 = n_rd;
    do_req(a, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t5_refill_beats", 32'(n_rd - r0), 32'd4);
    check("t5_latency", 32'(lat), 32'd5);

    // Write hit with no lanes enabled still marks the line dirty.
    do_req(12'h300, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    do_req(12'h304, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, lat, rd);
    check("t6_wr_latency", 32'(lat), 32'd0);
    do_req(12'h304, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t6_unchanged", rd, dram[12'h304 >> 2]);
    w0 = n_wr;
    do_req(12'h400, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("t6_writeback_beats", 32'(n_wr - w0), 32'd4);

    // Request withdrawn mid-burst: the latched line still fills and then hits.
    do_req(12'h580, 1'b0, 32'h0, 4'h0, 1'b1, lat, rd);
    do_req(12'h588, 1'b0, 32'h0, 4'h0, 1'b0, lat, rd);
    check("drop_then_hit_latency", 32'(lat), 32'd0);

    // Randomized traffic over a few indices to force conflicts, with random DRAM stalls.
    rand_delay = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        s_req = 1'b0;
        step();
        check("idle_ready", 32'(dcache_data_ready), 32'h0);
        check("idle_mem_req", 32'(mem_req), 32'h0);
      end
      a = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      do_req(a, 1'($urandom), $urandom, 4'($urandom), 1'b0, lat, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
